// File: rtl/controlador_registrador7b.sv
// Control stage for the 7-bit load/shift register.
// Accepts a word, loads it, issues paced shifts, then returns to hold.
module controlador_registrador7b #(
  parameter int LARGURA = 7,
  parameter int DIVISOR = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dado_valido,
  input  logic [LARGURA-1:0] dado_entrada,
  input  logic               serial_in,
  output logic               dado_pronto,
  output logic [LARGURA-1:0] valores_registrador,
  output logic               ch1,
  output logic               ch0,
  output logic               sinal,
  output logic               d,
  output logic               ocupado,
  output logic               fim,
  output logic [2:0]         contagem
);

  localparam logic [7:0] PRESC_INI = 8'(DIVISOR - 1);
  localparam logic [2:0] CONT_MAX  = 3'(LARGURA);

  typedef enum logic [1:0] {
    ESPERA,
    CARREGA,
    DESLOCA,
    FIM
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] palavra_q, palavra_d;
  logic [7:0]         presc_q, presc_d;
  logic [2:0]         contagem_q, contagem_d;

  always_comb begin
    estado_d    = estado_q;
    palavra_d   = palavra_q;
    presc_d     = presc_q;
    contagem_d  = contagem_q;
    ch1         = 1'b1;
    ch0         = 1'b0;
    sinal       = 1'b1;
    d           = 1'b0;
    dado_pronto = 1'b0;
    ocupado     = 1'b0;
    fim         = 1'b0;
    unique case (estado_q)
      ESPERA: begin
        dado_pronto = 1'b1;
        if (dado_valido) begin
          palavra_d = dado_entrada;
          estado_d  = CARREGA;
        end
      end
      CARREGA: begin
        sinal      = 1'b0;
        ch1        = 1'b0;
        ocupado    = 1'b1;
        presc_d    = PRESC_INI;
        contagem_d = 3'd0;
        estado_d   = DESLOCA;
      end
      DESLOCA: begin
        ocupado = 1'b1;
        if (presc_q != 8'd0) begin
          presc_d = presc_q - 8'd1;
        end else begin
          // one-cycle shift pulse; count shown includes this shift
          ch1        = 1'b0;
          ch0        = 1'b1;
          d          = serial_in;
          contagem_d = contagem_q + 3'd1;
          presc_d    = PRESC_INI;
          if (contagem_d == CONT_MAX) begin
            fim      = 1'b1;
            estado_d = FIM;
          end
        end
      end
      FIM: begin
        estado_d = ESPERA;
      end
      default: begin
        estado_d = ESPERA;
      end
    endcase
  end

  assign valores_registrador = palavra_q;
  assign contagem            = contagem_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= ESPERA;
      palavra_q  <= '0;
      presc_q    <= '0;
      contagem_q <= '0;
    end else begin
      estado_q   <= estado_d;
      palavra_q  <= palavra_d;
      presc_q    <= presc_d;
      contagem_q <= contagem_d;
    end
  end

endmodule

// File: tb/tb_controlador_registrador7b.sv
// Bench for controlador_registrador7b: DIVISOR=4 and DIVISOR=1 instances
// checked each cycle against a timeline model through a scoreboard queue.
module tb_controlador_registrador7b;

  localparam int L = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       ser;
  logic       vv[2];
  logic [6:0] ee[2];
  logic       pr[2], c1[2], c0[2], sn[2], dd[2], oc[2], fm[2];
  logic [6:0] val[2];
  logic [2:0] ct[2];

  controlador_registrador7b #(.LARGURA(7), .DIVISOR(4)) u4 (
    .clk(clk), .reset(reset), .dado_valido(vv[0]),
    .dado_entrada(ee[0]), .serial_in(ser), .dado_pronto(pr[0]),
    .valores_registrador(val[0]), .ch1(c1[0]), .ch0(c0[0]),
    .sinal(sn[0]), .d(dd[0]), .ocupado(oc[0]), .fim(fm[0]),
    .contagem(ct[0])
  );

  controlador_registrador7b #(.LARGURA(7), .DIVISOR(1)) u1 (
    .clk(clk), .reset(reset), .dado_valido(vv[1]),
    .dado_entrada(ee[1]), .serial_in(ser), .dado_pronto(pr[1]),
    .valores_registrador(val[1]), .ch1(c1[1]), .ch0(c0[1]),
    .sinal(sn[1]), .d(dd[1]), .ocupado(oc[1]), .fim(fm[1]),
    .contagem(ct[1])
  );

  typedef struct {
    logic [1:0] mode;
    logic       sinal, pronto, ocup, fim, d;
    logic [2:0] cont;
    logic [6:0] val;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic       fim;
    logic [2:0] cont;
    logic       pronto;
    logic       sinal;
  } pt_t;

  exp_t sb[$];
  pt_t  tab[9];
  int   total = 0;
  int   bad = 0;
  int   rel = 0;
  bit   tab_on = 0;

  bit         busy[2];
  int         age[2];
  int         dv[2];
  logic [6:0] mw[2];
  logic [2:0] mc[2];

  task automatic chk(string n, int k, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d] got=%0h want=%0h t=%0t", n, k, act, exp, $time);
    end
  endtask

  // expected outputs from cycles elapsed since acceptance
  function automatic exp_t model(int k, logic s);
    exp_t e;
    int a = age[k];
    int D = dv[k];
    int last = 1 + L * D;
    e.mode = 2'b10; e.sinal = 1'b1; e.pronto = 1'b0; e.ocup = 1'b0;
    e.fim = 1'b0; e.d = 1'b0; e.cont = mc[k]; e.val = mw[k];
    if (!busy[k]) begin
      e.pronto = 1'b1;
    end else if (a == 1) begin
      e.mode = 2'b00; e.sinal = 1'b0; e.ocup = 1'b1; e.cont = 3'd0;
    end else if (a <= last) begin
      e.ocup = 1'b1;
      e.cont = 3'((a - 1) / D);
      if ((a - 1) % D == 0) begin
        e.mode = 2'b01;
        e.d = s;
      end
      e.fim = (a == last);
    end else begin
      e.cont = 3'(L);
    end
    return e;
  endfunction

  task automatic model_edge(int k);
    if (reset) begin
      busy[k] = 1'b0; age[k] = 0; mw[k] = '0; mc[k] = '0;
    end else if (!busy[k]) begin
      if (vv[k]) begin
        busy[k] = 1'b1; age[k] = 1; mw[k] = ee[k];
      end
    end else begin
      age[k]++;
      if (age[k] > 2 + L * dv[k]) begin
        busy[k] = 1'b0;
        mc[k] = 3'(L);
      end
    end
  endtask

  task automatic step();
    exp_t e;
    for (int k = 0; k < 2; k++) sb.push_back(model(k, ser));
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      chk("mode", k, 8'({c1[k], c0[k]}), 8'(e.mode));
      chk("sinal", k, 8'(sn[k]), 8'(e.sinal));
      chk("pronto", k, 8'(pr[k]), 8'(e.pronto));
      chk("ocupado", k, 8'(oc[k]), 8'(e.ocup));
      chk("fim", k, 8'(fm[k]), 8'(e.fim));
      chk("d", k, 8'(dd[k]), 8'(e.d));
      chk("contagem", k, 8'(ct[k]), 8'(e.cont));
      chk("valor", k, 8'(val[k]), 8'(e.val));
    end
    if (tab_on) begin
      for (int i = 0; i < 9; i++) begin
        if (tab[i].cyc == rel) begin
          chk("tab_mode", 0, 8'({c1[0], c0[0]}), 8'(tab[i].mode));
          chk("tab_fim", 0, 8'(fm[0]), 8'(tab[i].fim));
          chk("tab_cont", 0, 8'(ct[0]), 8'(tab[i].cont));
          chk("tab_pronto", 0, 8'(pr[0]), 8'(tab[i].pronto));
          chk("tab_sinal", 0, 8'(sn[0]), 8'(tab[i].sinal));
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    rel++;
    #1;
  endtask

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      ser = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic chk_reset_vals(int k);
    chk("rst_ch1", k, 8'(c1[k]), 8'd1);
    chk("rst_ch0", k, 8'(c0[k]), 8'd0);
    chk("rst_sinal", k, 8'(sn[k]), 8'd1);
    chk("rst_pronto", k, 8'(pr[k]), 8'd1);
    chk("rst_valor", k, 8'(val[k]), 8'd0);
    chk("rst_cont", k, 8'(ct[k]), 8'd0);
    chk("rst_fim", k, 8'(fm[k]), 8'd0);
    chk("rst_ocup", k, 8'(oc[k]), 8'd0);
  endtask

  initial begin
    int n;
    tab[0] = '{0,  2'b10, 1'b0, 3'd0, 1'b1, 1'b1};
    tab[1] = '{1,  2'b00, 1'b0, 3'd0, 1'b0, 1'b0};
    tab[2] = '{4,  2'b10, 1'b0, 3'd0, 1'b0, 1'b1};
    tab[3] = '{5,  2'b01, 1'b0, 3'd1, 1'b0, 1'b1};
    tab[4] = '{9,  2'b01, 1'b0, 3'd2, 1'b0, 1'b1};
    tab[5] = '{28, 2'b10, 1'b0, 3'd6, 1'b0, 1'b1};
    tab[6] = '{29, 2'b01, 1'b1, 3'd7, 1'b0, 1'b1};
    tab[7] = '{30, 2'b10, 1'b0, 3'd7, 1'b0, 1'b1};
    tab[8] = '{31, 2'b10, 1'b0, 3'd7, 1'b1, 1'b1};
    dv[0] = 4; dv[1] = 1;
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; age[k] = 0; mw[k] = '0; mc[k] = '0;
      vv[k] = 1'b0; ee[k] = '0;
    end
    ser = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_vals(0);
    chk_reset_vals(1);
    cyc(2);

    // single word on the DIVISOR=4 instance
    vv[0] = 1'b1; ee[0] = 7'b1010011; rel = 0; tab_on = 1;
    cyc(1);
    vv[0] = 1'b0;
    cyc(34);
    tab_on = 0;

    // back-to-back words on the DIVISOR=1 instance, valid held high
    vv[1] = 1'b1; ee[1] = 7'b0101010;
    cyc(1);
    ee[1] = 7'b1100110;
    cyc(19);
    vv[1] = 1'b0;
    cyc(3);
    chk("b2b_valor", 1, 8'(val[1]), 8'(7'b1100110));

    // busy ignore
    vv[0] = 1'b1; ee[0] = 7'b0000001;
    cyc(1);
    vv[0] = 1'b0;
    cyc(9);
    vv[0] = 1'b1; ee[0] = 7'b1111111;
    cyc(1);
    vv[0] = 1'b0;
    cyc(2);
    chk("busy_valor", 0, 8'(val[0]), 8'(7'b0000001));
    cyc(30);

    // serial in high only on expected shift cycles
    vv[0] = 1'b1; ee[0] = 7'b0011100;
    ser = 1'b0;
    step();
    vv[0] = 1'b0;
    for (int i = 0; i < 33; i++) begin
      ser = (model(0, 1'b1).mode == 2'b01);
      step();
    end

    // reset mid-shift at contagem=3
    vv[0] = 1'b1; ee[0] = 7'b0110101;
    cyc(1);
    vv[0] = 1'b0;
    n = 0;
    while (!(busy[0] && age[0] > 1 && model(0, 1'b0).cont == 3'd3)
           && n < 40) begin
      cyc(1);
      n++;
    end
    chk("wait_cont3", 0, 8'(n < 40), 8'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk_reset_vals(0);
    cyc(2);
    vv[0] = 1'b1; ee[0] = 7'b1001110;
    cyc(1);
    vv[0] = 1'b0;
    cyc(34);
    chk("post_rst_valor", 0, 8'(val[0]), 8'(7'b1001110));
    chk("post_rst_cont", 0, 8'(ct[0]), 8'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlador_registrador7b.md
Name: controlador_registrador7b

Overview:
- Control stage that sits directly upstream of the 7-bit register built from the per-bit load/shift flip-flops.
- Accepts a parallel word through a valid/ready handshake and drives the register's bus: mode selects ch1/ch0, override sinal, parallel value and serial-in bit d.
- Sequences load, then LARGURA paced shifts, then hold. Reports done and busy to the game/display logic.

Parameters:
- LARGURA, 7, register width in bits; also the number of shifts per word.
- DIVISOR, 4, clock cycles between consecutive shifts (pacing prescaler); legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- dado_valido  input  1  upstream word available.
- dado_entrada  input  LARGURA  parallel word to load.
- serial_in  input  1  bit shifted into the register's vacant end during each shift.
- dado_pronto  output  1  ready: controller can accept a word.
- valores_registrador  output  LARGURA  parallel value presented to the register.
- ch1  output  1  mux select MSB.
- ch0  output  1  mux select LSB.
- sinal  output  1  1 = mux path active; 0 = force parallel value into every bit.
- d  output  1  serial bit to the register.
- ocupado  output  1  word in progress.
- fim  output  1  one-cycle pulse when the last shift is issued.
- contagem  output  3  shifts issued for the current word (0..LARGURA).

Behaviour:
- Mode encoding on {ch1,ch0}:
  - 00 = load valores_registrador.
  - 01 = shift.
  - 10 = hold (d path, d driven with the bit to recirculate is the register's job; controller only selects).
  - 11 = unused, never driven.
- State ESPERA (reset state):
  - Outputs: {ch1,ch0}=10, sinal=1, dado_pronto=1, ocupado=0.
  - On dado_valido&&dado_pronto: capture dado_entrada into an internal holding register, go CARREGA.
- State CARREGA, exactly 1 cycle:
  - Outputs: valores_registrador=captured word, sinal=0, {ch1,ch0}=00, dado_pronto=0, ocupado=1.
  - The register samples the word at the end of this cycle. Go to DESLOCA.
  - Prescaler := DIVISOR-1; contagem := 0.
- State DESLOCA:
  - While prescaler != 0: decrement prescaler; {ch1,ch0}=10 (hold).
  - When prescaler == 0: {ch1,ch0}=01 for exactly one cycle, d=serial_in, contagem+1, prescaler reloads DIVISOR-1.
  - The shift that makes contagem==LARGURA asserts fim in that same cycle; go FIM.
  - With DIVISOR=1, a shift occurs every cycle.
- State FIM, 1 cycle:
  - {ch1,ch0}=10, ocupado=0, contagem holds LARGURA. Return to ESPERA.
  - dado_pronto=1 is first seen in ESPERA, one cycle after FIM.
- Output defaults:
  - valores_registrador holds the last captured word outside CARREGA; 0 after reset.
  - d=0 outside shift cycles.
  - sinal=1 in every state except CARREGA.
- Latency: acceptance at cycle T gives load at T+1. First shift at T+1+DIVISOR. fim at T+1+LARGURA*DIVISOR. Next acceptance possible at T+3+LARGURA*DIVISOR.
- dado_valido while busy is ignored, not queued; dado_pronto=0 throughout.
- reset mid-word: next edge forces ESPERA. All outputs return to reset values: ch1=1, ch0=0, sinal=1, valores_registrador=0, contagem=0, fim=0, ocupado=0, dado_pronto=1. No partial shift completes.
- contagem wraps to 0 only on a new load; it never exceeds LARGURA.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → ch1=1, ch0=0, sinal=1, dado_pronto=1, valores_registrador=0, contagem=0.
- Single word, DIVISOR=4: dado_entrada=7'b1010011, valid at cycle 0 → cycle 1 shows sinal=0 with 00 and value 1010011. Shifts (01) at cycles 5,9,…,29. fim high only at cycle 29 with contagem=7. dado_pronto=1 again at cycle 31.
- DIVISOR=1 back-to-back: two words, valid held high → shifts on 7 consecutive cycles. Second load occurs 3 cycles after the first fim; no gap or extra shift.
- Busy ignore: pulse dado_valido with 7'b1111111 during DESLOCA of word 7'b0000001 → captured value unchanged, contagem sequence unaffected.
- Serial-in pass-through: serial_in=1 during shift cycles, 0 otherwise → d=1 exactly in the cycles where {ch1,ch0}=01.
- Reset mid-shift: assert reset at contagem=3 → next cycle in ESPERA with all reset values, no fim pulse. A new word then completes normally.
